score_bcd: RTL and testbench
============================

# score_bcd

Sequential binary-to-BCD converter between the game's score counter and the seven-segment scan logic. It watches the binary score and re-converts whenever the value changes, using an iterative shift-and-add-3 (double-dabble) engine. It presents four registered, atomically updated BCD digits, with optional leading-zero blanking, so the seven-segment digit mux can take them directly with no divide/modulo logic. Value 4'hF is the codepoint the seven-segment decoder renders as blank.

## Interface
- `W`, 10: binary score width. Legal range 4..13, so the result always fits in 4 digits.
- `BLANK_LZ`, 1: when 1, leading-zero digits are output as 4'hF. Digit 0 is never blanked.
- `clk` input 1: system clock. All state changes on the rising edge.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `score` input W: binary score. Sampled only in IDLE.
- `force` input 1: request a conversion even if `score` is unchanged. Honoured only in IDLE.
- `dig0` output 4: BCD ones digit.
- `dig1` output 4: BCD tens digit, or 4'hF if blanked.
- `dig2` output 4: BCD hundreds digit, or 4'hF if blanked.
- `dig3` output 4: BCD thousands digit, or 4'hF if blanked.
- `busy` output 1: high while a conversion is in flight (SHIFT and DONE).
- `upd` output 1: one-cycle pulse in the cycle the new digits first appear.

## Operation
- Internal registers:
  - `last`: width W, holds the last value accepted for conversion.
  - `sr`: width W+16, the double-dabble register; BCD field is the upper 16 bits, binary field the lower W bits.
  - `cnt`: counts shift steps 0..W-1.
- IDLE:
  - If `score != last` or `force`=1: load `sr` = {16'h0, score}, set `last` = score, clear `cnt`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, once per cycle:
  - Add 3 to every BCD nibble of `sr` that is >= 5.
  - Then shift `sr` left by 1.
  - `cnt` increments. When `cnt` == W-1, go to DONE.
  - SHIFT lasts exactly W cycles.
- DONE:
  - Copy the BCD nibbles to `dig3..dig0`, applying blanking.
  - Assert `upd` for this one cycle only, then return to IDLE.
- Blanking (BLANK_LZ=1):
  - `dig3` is blanked if its value is 0.
  - `dig2` is blanked if it and `dig3` are both 0.
  - `dig1` is blanked if it, `dig2` and `dig3` are all 0.
  - Interior zeros are shown, e.g. 100 displays as F,1,0,0.
- `score` changes during SHIFT or DONE are ignored until the FSM is back in IDLE. The next IDLE cycle compares against `last`, so the final value is always converted. Intermediate values may be skipped.
- `force` is ignored outside IDLE; it is not queued.
- Arithmetic: the add-3 is done nibble-wise with no carry between nibbles. The shift is a logical left shift; the bit shifted out of the top of `sr` is discarded and is always 0 for legal W.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - FSM = IDLE, `last` = 0, `sr` = 0, `cnt` = 0.
  - `busy` = 0, `upd` = 0.
  - `dig0` = 0.
  - `dig1..dig3` = 4'hF if BLANK_LZ=1, otherwise 0. This matches the converted value of 0.
- A score of 0 after reset causes no conversion, because `last` resets to 0.
- Latency: the change is detected on edge E0 (IDLE). Shift edges are E1..EW. DONE is entered on edge EW, and the digits and `upd` are registered on edge EW+1. For W=10, outputs change 11 cycles after the detecting edge. Conversion occupancy is W+1 cycles.
- `busy` is high from the cycle after E0 until the cycle after the DONE cycle, W+1 cycles total. It is a registered state decode.
- `dig*` hold their value between updates and change only on the DONE edge; all four change on the same edge.
- Back-to-back conversions: the minimum gap between `upd` pulses is W+2 cycles.
- If `reset_n` is asserted mid-conversion, all registers return to reset values immediately and the partial result is discarded.

## Structure
- Shared package `score_pkg`:
  - `BCD_BLANK` = 4'hF.
  - The FSM state type {IDLE, SHIFT, DONE}.
  - `NDIG` = 4.
- One sub-module, `bcd_add3`: 4-bit combinational, returns in>=5 ? in+3 : in. It is instantiated 4 times across the BCD field of `sr`.
- Blanking is a small combinational block in the top module, feeding the output registers.

## Test plan
- Reset with `score`=0, hold 20 cycles -> `dig3..0` = F,F,F,0; `upd` never asserts; `busy`=0.
- `score` 0->57 -> `busy` high for 11 cycles; `upd` pulses once; digits = F,F,5,7 exactly 11 cycles after the detecting edge.
- `score`=1023 -> 1,0,2,3. `score`=100 -> F,1,0,0. With BLANK_LZ=0, `score`=7 -> 0,0,0,7.
- `score`=5, then 6 written 3 cycles into SHIFT -> first `upd` shows F,F,F,5; a second conversion follows immediately; the second `upd` shows F,F,F,6.
- `force` pulse with `score` unchanged at 42 -> one conversion, digits stay F,F,4,2, `upd` pulses once. `force` held during SHIFT -> no extra conversion.
- `reset_n` low at shift step 4 of a 999 conversion -> outputs at reset values in the same cycle. On release with `score`=42 -> conversion runs and shows F,F,4,2.

Source files
------------

// File: rtl/score_bcd_pkg.sv
// Shared definitions for the score binary-to-BCD converter.
package score_pkg;

    // Number of BCD digits presented to the seven-segment mux.
    localparam int NDIG = 4;

    // Codepoint the seven-segment decoder renders as an unlit digit.
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/score_bcd_add3.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] in_i,
    output logic [3:0] out_o
);

    // Nibble-local correction; no carry leaves the nibble.
    assign out_o = (in_i >= 4'd5) ? (in_i + 4'd3) : in_i;

endmodule

// File: rtl/score_bcd.sv
// Sequential binary-to-BCD converter for the score display. Re-converts whenever
// the score changes (or on request) and presents four atomically updated digits,
// optionally with leading zeros replaced by the blank codepoint.
module score_bcd
    import score_pkg::*;
#(
    parameter int W        = 10,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] score_i,
    input  logic         force_i,
    output logic [3:0]   dig0_o,
    output logic [3:0]   dig1_o,
    output logic [3:0]   dig2_o,
    output logic [3:0]   dig3_o,
    output logic         busy_o,
    output logic         upd_o
);

    localparam int         CW      = (W > 1) ? $clog2(W) : 1;
    localparam int         SRW     = W + 16;
    localparam logic [3:0] HI_RST  = BLANK_LZ ? BCD_BLANK : 4'h0;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    state_t                      state_q, state_d;
    logic [W-1:0]                last_q, last_d;
    logic [SRW-1:0]              sr_q, sr_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [NDIG-1:0][3:0]        dig_q;
    logic [NDIG-1:0][3:0]        dig_blk;
    logic [NDIG-1:0][3:0]        bcd_raw;
    logic [15:0]                 bcd_adj;
    logic [SRW-1:0]              sr_adj;
    logic                        busy_q;
    logic                        upd_q;

    // One add-3 corrector per BCD nibble of the shift register.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_add3
        assign bcd_raw[gi] = sr_q[W + 4*gi +: 4];
        bcd_add3 u_add3 (
            .in_i  (bcd_raw[gi]),
            .out_o (bcd_adj[4*gi +: 4])
        );
    end

    assign sr_adj = {bcd_adj, sr_q[W-1:0]};

    // Leading-zero blanking of the finished BCD field; digit 0 is always shown.
    always_comb begin
        logic lead;
        lead    = 1'b1;
        dig_blk = bcd_raw;
        for (int i = NDIG - 1; i >= 1; i--) begin
            lead = lead && (bcd_raw[i] == 4'h0);
            if (BLANK_LZ && lead) begin
                dig_blk[i] = BCD_BLANK;
            end
        end
    end

    // Next-state logic: start on change or request, shift W times, then publish.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if ((score_i != last_q) || force_i) begin
                    sr_d    = {16'h0, score_i};
                    last_d  = score_i;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d = sr_adj << 1;
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset matches the displayed value of 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            dig_q   <= {HI_RST, HI_RST, HI_RST, 4'h0};
            busy_q  <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            upd_q   <= (state_q == DONE);
            if (state_q == DONE) begin
                dig_q <= dig_blk;
            end
        end
    end

    assign dig0_o = dig_q[0];
    assign dig1_o = dig_q[1];
    assign dig2_o = dig_q[2];
    assign dig3_o = dig_q[3];
    assign busy_o = busy_q;
    assign upd_o  = upd_q;

endmodule

// File: tb/tb_score_bcd.sv
// Self-checking bench for score_bcd: a blanking instance and a non-blanking
// instance share stimulus; expected digits come from decimal arithmetic.
module tb_score_bcd;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] score = '0;
    logic         force_i = 1'b0;

    logic [3:0] b0, b1, b2, b3, n0, n1, n2, n3;
    logic       busy_b, upd_b, busy_n, upd_n;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    score_bcd #(.W(W), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .score_i(score), .force_i(force_i),
        .dig0_o(b0), .dig1_o(b1), .dig2_o(b2), .dig3_o(b3),
        .busy_o(busy_b), .upd_o(upd_b)
    );

    score_bcd #(.W(W), .BLANK_LZ(1'b0)) dut_n (
        .clk(clk), .reset_n(reset_n), .score_i(score), .force_i(force_i),
        .dig0_o(n0), .dig1_o(n1), .dig2_o(n2), .dig3_o(n3),
        .busy_o(busy_n), .upd_o(upd_n)
    );

    typedef struct {
        int unsigned val;
        logic [15:0] exp_b;
        logic [15:0] exp_n;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [15:0] digs_b();
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [15:0] digs_n();
        return {n3, n2, n1, n0};
    endfunction

    // Decimal reference: digits by division, blanking by magnitude.
    function automatic logic [15:0] model(input int unsigned v, input bit blank);
        logic [3:0] d3, d2, d1, d0;
        d0 = 4'(v % 10);
        d1 = 4'((v / 10) % 10);
        d2 = 4'((v / 100) % 10);
        d3 = 4'((v / 1000) % 10);
        if (blank) begin
            if (v < 1000) d3 = 4'hF;
            if (v < 100)  d2 = 4'hF;
            if (v < 10)   d1 = 4'hF;
        end
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Waits for the next upd pulse of the blanking instance; k = negedges waited
    // (-1 on timeout). Any force pulse is dropped after one cycle.
    task automatic wait_upd(output int k, output int busy_cnt);
        k = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) force_i = 1'b0;
            if (busy_b) busy_cnt++;
            if (upd_b) begin
                k = i;
                break;
            end
        end
    endtask

    int k, bc, cnt_u, cnt_busy;
    int unsigned v, cur;

    initial begin
        tbl[0] = '{57,   16'hFF57, 16'h0057};
        tbl[1] = '{1023, 16'h1023, 16'h1023};
        tbl[2] = '{100,  16'hF100, 16'h0100};
        tbl[3] = '{7,    16'hFFF7, 16'h0007};
        tbl[4] = '{999,  16'hF999, 16'h0999};
        tbl[5] = '{0,    16'hFFF0, 16'h0000};
        tbl[6] = '{42,   16'hFF42, 16'h0042};

        // Reset with score 0, then 20 idle cycles: nothing should happen.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cnt_u = 0;
        cnt_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd_b || upd_n) cnt_u++;
            if (busy_b || busy_n) cnt_busy++;
        end
        chk("idle_upd_count", cnt_u, 0);
        chk("idle_busy_count", cnt_busy, 0);
        chk("reset_digits_blank", digs_b(), 16'hFFF0);
        chk("reset_digits_noblank", digs_n(), 16'h0000);
        $display("reset idle: digits=%h/%h", digs_b(), digs_n());

        // Table of conversions: latency, busy length, digits, one-cycle upd.
        for (int t = 0; t < 7; t++) begin
            score = W'(tbl[t].val);
            wait_upd(k, bc);
            chk("tbl_latency", k, W + 2);
            chk("tbl_busy_cycles", bc, W + 1);
            chk("tbl_digits_blank", digs_b(), tbl[t].exp_b);
            chk("tbl_digits_noblank", digs_n(), tbl[t].exp_n);
            chk("tbl_upd_noblank", upd_n, 1);
            $display("convert score=%0d digits=%h/%h latency=%0d", tbl[t].val, digs_b(), digs_n(), k);
            @(negedge clk);
            chk("tbl_upd_one_cycle", upd_b, 0);
        end

        // Force with unchanged score: exactly one conversion, same digits.
        force_i = 1'b1;
        wait_upd(k, bc);
        chk("force_latency", k, W + 2);
        chk("force_digits", digs_b(), 16'hFF42);
        $display("force pulse score=42 digits=%h", digs_b());
        cnt_u = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd_b) cnt_u++;
        end
        chk("force_single_upd", cnt_u, 0);

        // Force held through SHIFT: only the initial conversion occurs.
        force_i = 1'b1;
        cnt_u = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 10) force_i = 1'b0;
            if (upd_b) cnt_u++;
        end
        chk("force_held_upd_count", cnt_u, 1);
        chk("force_held_digits", digs_b(), 16'hFF42);
        $display("force held score=42 upd_count=%0d", cnt_u);

        // Score changes 3 cycles into SHIFT: both values convert, back to back.
        score = W'(5);
        repeat (4) @(negedge clk);
        score = W'(6);
        wait_upd(k, bc);
        chk("midchange_first", digs_b(), 16'hFFF5);
        wait_upd(k, bc);
        chk("midchange_gap", k, W + 2);
        chk("midchange_second", digs_b(), 16'hFFF6);
        $display("midchange 5->6 digits=%h gap=%0d", digs_b(), k);

        // Reset mid-conversion of 999: immediate reset values, then 42 converts.
        score = W'(999);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        score = W'(42);
        #1;
        chk("midreset_busy", busy_b, 0);
        chk("midreset_upd", upd_b, 0);
        chk("midreset_digits_blank", digs_b(), 16'hFFF0);
        chk("midreset_digits_noblank", digs_n(), 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        wait_upd(k, bc);
        chk("postreset_latency", k, W + 2);
        chk("postreset_digits", digs_b(), 16'hFF42);
        $display("reset mid-999 then score=42 digits=%h", digs_b());

        // Randomized conversions against the decimal model.
        cur = 42;
        for (int r = 0; r < 24; r++) begin
            v = $urandom_range(0, (1 << W) - 1);
            force_i = (v == cur) ? 1'b1 : 1'($urandom_range(0, 1));
            score = W'(v);
            wait_upd(k, bc);
            chk("rand_latency", k, W + 2);
            chk("rand_digits_blank", digs_b(), model(v, 1'b1));
            chk("rand_digits_noblank", digs_n(), model(v, 1'b0));
            $display("random score=%0d digits=%h/%h", v, digs_b(), digs_n());
            cur = v;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
